// File: rtl/ssd1306_seq_if.sv
// Command/handshake bundle between the SSD1306 sequencer (master) and i2c_api (slave).
interface ssd1306_seq_if;
    logic       i2c_enable;
    logic [7:0] i2c_function;
    logic [7:0] i2c_dev_reg;
    logic [7:0] i2c_data_tx;
    logic       i2c_ready;
    logic       i2c_done;

    modport master (
        output i2c_enable, i2c_function, i2c_dev_reg, i2c_data_tx,
        input  i2c_ready, i2c_done
    );
    modport slave (
        input  i2c_enable, i2c_function, i2c_dev_reg, i2c_data_tx,
        output i2c_ready, i2c_done
    );
endinterface

// File: rtl/ssd1306_seq.sv
// SSD1306 sequencer: power-up delay, init command list, then framebuffer flushes to GDDRAM
// through i2c_api, one command at a time with a watchdog on every command.
module ssd1306_seq #(
    parameter int unsigned CLK_FREQ     = 25_000_000,
    parameter int unsigned PWRUP_US     = 1000,
    parameter int unsigned HEIGHT       = 64,
    parameter int unsigned TIMEOUT      = 2_000_000,
    parameter logic [7:0]  FN_IDLE      = 8'h00,
    parameter logic [7:0]  FN_WRITE_8   = 8'h01,
    parameter logic [7:0]  FN_WRITE_RAW = 8'h02,
    parameter logic [7:0]  FN_START     = 8'h03,
    parameter logic [7:0]  FN_STOP      = 8'h04,
    localparam int unsigned FB_BYTES    = 128 * HEIGHT / 8,
    localparam int unsigned AW          = $clog2(FB_BYTES)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush_req,
    output logic          init_done,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] fb_addr,
    input  logic [7:0]    fb_data,
    ssd1306_seq_if.master i2c
);

    localparam int unsigned CW       = AW + 1;
    localparam int unsigned PWR_CYC  = CLK_FREQ / 1_000_000 * PWRUP_US;
    localparam int unsigned PWR_LAST = (PWR_CYC > 0) ? PWR_CYC - 1 : 0;
    localparam int unsigned PW       = $clog2(PWR_CYC + 2);
    localparam int unsigned WDW      = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_PWRUP, S_INIT, S_IDLE, S_WIN, S_START, S_CTRL, S_DATA, S_STOP, S_ERR
    } state_t;

    state_t         state_r;
    logic           init_done_r, busy_r, err_r, en_r, cmd_act_r, gap_r;
    logic [AW-1:0]  fb_addr_r;
    logic [7:0]     fn_r, dev_r, tx_r;
    logic [PW-1:0]  pwr_r;
    logic [WDW-1:0] wd_r;
    logic [4:0]     idx_r;
    logic [CW-1:0]  cnt_r;

    function automatic logic [7:0] init_byte(input logic [4:0] i);
        case (i)
            5'd0:    init_byte = 8'hAE;
            5'd1:    init_byte = 8'hD5;
            5'd2:    init_byte = 8'h80;
            5'd3:    init_byte = 8'hA8;
            5'd4:    init_byte = 8'(HEIGHT - 1);
            5'd5:    init_byte = 8'hD3;
            5'd6:    init_byte = 8'h00;
            5'd7:    init_byte = 8'h40;
            5'd8:    init_byte = 8'h8D;
            5'd9:    init_byte = 8'h14;
            5'd10:   init_byte = 8'h20;
            5'd11:   init_byte = 8'h00;
            5'd12:   init_byte = 8'hA1;
            5'd13:   init_byte = 8'hC8;
            5'd14:   init_byte = 8'hDA;
            5'd15:   init_byte = (HEIGHT == 64) ? 8'h12 : 8'h02;
            5'd16:   init_byte = 8'h81;
            5'd17:   init_byte = 8'hCF;
            5'd18:   init_byte = 8'hD9;
            5'd19:   init_byte = 8'hF1;
            5'd20:   init_byte = 8'hDB;
            5'd21:   init_byte = 8'h40;
            5'd22:   init_byte = 8'hA4;
            5'd23:   init_byte = 8'hA6;
            5'd24:   init_byte = 8'hAF;
            default: init_byte = 8'hE3;
        endcase
    endfunction

    // Column range 0..127 and page range 0..last page, so the data stream fills the whole panel.
    function automatic logic [7:0] win_byte(input logic [4:0] i);
        case (i)
            5'd0:    win_byte = 8'h21;
            5'd1:    win_byte = 8'h00;
            5'd2:    win_byte = 8'h7F;
            5'd3:    win_byte = 8'h22;
            5'd4:    win_byte = 8'h00;
            5'd5:    win_byte = 8'(HEIGHT / 8 - 1);
            default: win_byte = 8'hE3;
        endcase
    endfunction

    // Sequencer FSM: issue one command, hold it until done, then FN_IDLE gap before the next.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= S_PWRUP;
            init_done_r <= 1'b0;
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            en_r        <= 1'b0;
            fn_r        <= FN_IDLE;
            dev_r       <= 8'h00;
            tx_r        <= 8'h00;
            fb_addr_r   <= '0;
            cmd_act_r   <= 1'b0;
            gap_r       <= 1'b0;
            pwr_r       <= '0;
            wd_r        <= '0;
            idx_r       <= 5'd0;
            cnt_r       <= '0;
        end else begin
            gap_r <= 1'b0;
            case (state_r)
                S_PWRUP: begin
                    if (pwr_r == PW'(PWR_LAST)) begin
                        state_r <= S_INIT;
                        en_r    <= 1'b1;
                    end else begin
                        pwr_r <= pwr_r + PW'(1);
                    end
                end
                S_IDLE: begin
                    if (flush_req) begin
                        state_r <= S_WIN;
                        busy_r  <= 1'b1;
                        idx_r   <= 5'd0;
                    end
                end
                S_ERR: begin
                    state_r <= S_ERR;
                end
                S_INIT, S_WIN, S_START, S_CTRL, S_DATA, S_STOP: begin
                    if (cmd_act_r) begin
                        if (i2c.i2c_done) begin
                            cmd_act_r <= 1'b0;
                            fn_r      <= FN_IDLE;
                            gap_r     <= 1'b1;
                            case (state_r)
                                S_INIT: begin
                                    if (idx_r == 5'd24) begin
                                        init_done_r <= 1'b1;
                                        busy_r      <= 1'b0;
                                        state_r     <= S_IDLE;
                                        idx_r       <= 5'd0;
                                    end else begin
                                        idx_r <= idx_r + 5'd1;
                                    end
                                end
                                S_WIN: begin
                                    if (idx_r == 5'd5) begin
                                        state_r <= S_START;
                                    end else begin
                                        idx_r <= idx_r + 5'd1;
                                    end
                                end
                                S_START: state_r <= S_CTRL;
                                S_CTRL: begin
                                    state_r   <= S_DATA;
                                    cnt_r     <= '0;
                                    fb_addr_r <= '0;
                                end
                                S_DATA: begin
                                    // Address only advances on non-final bytes, so it never wraps.
                                    if (cnt_r == CW'(FB_BYTES - 1)) begin
                                        state_r <= S_STOP;
                                    end else begin
                                        cnt_r     <= cnt_r + CW'(1);
                                        fb_addr_r <= cnt_r[AW-1:0] + AW'(1);
                                    end
                                end
                                S_STOP: begin
                                    state_r <= S_IDLE;
                                    busy_r  <= 1'b0;
                                end
                                default: state_r <= S_ERR;
                            endcase
                        end else if (wd_r == WDW'(TIMEOUT - 1)) begin
                            err_r     <= 1'b1;
                            state_r   <= S_ERR;
                            fn_r      <= FN_IDLE;
                            en_r      <= 1'b0;
                            busy_r    <= 1'b0;
                            cmd_act_r <= 1'b0;
                        end else begin
                            wd_r <= wd_r + WDW'(1);
                        end
                    end else if (!gap_r && i2c.i2c_ready) begin
                        cmd_act_r <= 1'b1;
                        wd_r      <= '0;
                        dev_r     <= 8'h00;
                        case (state_r)
                            S_INIT: begin
                                fn_r <= FN_WRITE_8;
                                tx_r <= init_byte(idx_r);
                            end
                            S_WIN: begin
                                fn_r <= FN_WRITE_8;
                                tx_r <= win_byte(idx_r);
                            end
                            S_START: begin
                                fn_r <= FN_START;
                                tx_r <= 8'h00;
                            end
                            S_CTRL: begin
                                fn_r <= FN_WRITE_RAW;
                                tx_r <= 8'h40;
                            end
                            S_DATA: begin
                                fn_r <= FN_WRITE_RAW;
                                tx_r <= fb_data;
                            end
                            S_STOP: begin
                                fn_r <= FN_STOP;
                                tx_r <= 8'h00;
                            end
                            default: fn_r <= FN_IDLE;
                        endcase
                    end
                end
                default: begin
                    state_r <= S_ERR;
                    err_r   <= 1'b1;
                    en_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    fn_r    <= FN_IDLE;
                end
            endcase
        end
    end

    assign init_done        = init_done_r;
    assign busy             = busy_r;
    assign err              = err_r;
    assign fb_addr          = fb_addr_r;
    assign i2c.i2c_enable   = en_r;
    assign i2c.i2c_function = fn_r;
    assign i2c.i2c_dev_reg  = dev_r;
    assign i2c.i2c_data_tx  = tx_r;

endmodule

// File: tb/tb_ssd1306_seq.sv
// Directed bench for ssd1306_seq: behavioural i2c_api responder with command log, sync-RAM framebuffer.
module tb_ssd1306_seq;
    localparam int unsigned CLK_FREQ   = 1_000_000;
    localparam int unsigned PWRUP_US   = 40;
    localparam int unsigned HEIGHT     = 64;
    localparam int unsigned TIMEOUT    = 200;
    localparam int unsigned AW         = 10;
    localparam int          FLUSH_CMDS = 6 + 1 + 1 + 1024 + 1;
    localparam logic [7:0]  FN_IDLE    = 8'h00;
    localparam logic [7:0]  FN_W8      = 8'h01;
    localparam logic [7:0]  FN_RAW     = 8'h02;
    localparam logic [7:0]  FN_START   = 8'h03;
    localparam logic [7:0]  FN_STOP    = 8'h04;

    logic          clk = 1'b0;
    logic          resetn, flush_req, init_done, busy, err;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data = 8'h00;

    ssd1306_seq_if bus ();

    ssd1306_seq #(
        .CLK_FREQ(CLK_FREQ), .PWRUP_US(PWRUP_US), .HEIGHT(HEIGHT), .TIMEOUT(TIMEOUT),
        .FN_IDLE(FN_IDLE), .FN_WRITE_8(FN_W8), .FN_WRITE_RAW(FN_RAW),
        .FN_START(FN_START), .FN_STOP(FN_STOP)
    ) dut (
        .clk(clk), .resetn(resetn), .flush_req(flush_req), .init_done(init_done),
        .busy(busy), .err(err), .fb_addr(fb_addr), .fb_data(fb_data), .i2c(bus)
    );

    always #5 clk = ~clk;

    // Framebuffer holds fb[n] = n[7:0], one cycle read latency.
    always @(posedge clk) fb_data <= fb_addr[7:0];

    logic [7:0] log_fn  [0:8191];
    logic [7:0] log_dev [0:8191];
    logic [7:0] log_tx  [0:8191];
    int         log_cyc [0:8191];
    int         n_log = 0, n_stop = 0, stab_err = 0, hold_at = -1, lat = 20, cyc = 0, m_cnt = 0;
    logic       m_busy = 1'b0, m_hold = 1'b0;
    logic [7:0] l_fn, l_dev, l_tx;

    // i2c_api responder: accepts when ready, raises done lat cycles later unless told to withhold.
    always @(posedge clk) begin
        if (!resetn) begin
            cyc           <= 0;
            bus.i2c_ready <= 1'b1;
            bus.i2c_done  <= 1'b0;
            m_busy        <= 1'b0;
            m_cnt         <= 0;
        end else begin
            cyc          <= cyc + 1;
            bus.i2c_done <= 1'b0;
            if (bus.i2c_done) begin
                bus.i2c_ready <= 1'b1;
            end else if (m_busy) begin
                if (!err && (bus.i2c_function !== l_fn || bus.i2c_dev_reg !== l_dev ||
                             bus.i2c_data_tx !== l_tx || bus.i2c_enable !== 1'b1))
                    stab_err <= stab_err + 1;
                if (!m_hold) begin
                    if (m_cnt > 1) m_cnt <= m_cnt - 1;
                    else begin
                        bus.i2c_done <= 1'b1;
                        m_busy       <= 1'b0;
                    end
                end
            end else if (bus.i2c_ready && bus.i2c_enable && bus.i2c_function != FN_IDLE) begin
                if (n_log < 8192) begin
                    log_fn[n_log]  <= bus.i2c_function;
                    log_dev[n_log] <= bus.i2c_dev_reg;
                    log_tx[n_log]  <= bus.i2c_data_tx;
                    log_cyc[n_log] <= cyc;
                end
                n_log         <= n_log + 1;
                n_stop        <= n_stop + ((bus.i2c_function == FN_STOP) ? 1 : 0);
                m_hold        <= (n_log == hold_at);
                m_busy        <= 1'b1;
                m_cnt         <= lat;
                bus.i2c_ready <= 1'b0;
                l_fn          <= bus.i2c_function;
                l_dev         <= bus.i2c_dev_reg;
                l_tx          <= bus.i2c_data_tx;
            end
        end
    end

    function automatic logic [7:0] exp_init(input int i);
        logic [7:0] tbl [0:24];
        tbl = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
                8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        return tbl[i];
    endfunction

    function automatic logic [7:0] exp_win(input int i);
        logic [7:0] tbl [0:5];
        tbl = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        return tbl[i];
    endfunction

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_init_done"}, init_done, 32'd0);
        chk({pfx, "_busy"}, busy, 32'd1);
        chk({pfx, "_err"}, err, 32'd0);
        chk({pfx, "_fb_addr"}, fb_addr, 32'd0);
        chk({pfx, "_enable"}, bus.i2c_enable, 32'd0);
        chk({pfx, "_function"}, bus.i2c_function, FN_IDLE);
        chk({pfx, "_dev_reg"}, bus.i2c_dev_reg, 32'd0);
        chk({pfx, "_data_tx"}, bus.i2c_data_tx, 32'd0);
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    initial begin
        int t, b, k, bad;
        resetn    = 1'b0;
        flush_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        // Power-up delay, then the init list with a slow responder.
        resetn = 1'b1;
        repeat (35) @(negedge clk);
        chk("pwrup_no_cmd", n_log, 32'd0);
        chk("pwrup_enable", bus.i2c_enable, 32'd0);
        t = 0;
        while (!init_done && t < 4000) begin @(negedge clk); t++; end
        chk("init_done", init_done, 32'd1);
        chk("init_busy", busy, 32'd0);
        chk("init_count", n_log, 32'd25);
        chk("first_cmd_cycle", (log_cyc[0] >= 40 && log_cyc[0] <= 45), 32'd1);
        bad = 0;
        for (int i = 0; i < 25; i++) if (log_fn[i] !== FN_W8 || log_dev[i] !== 8'h00) bad++;
        chk("init_fn_dev", bad, 32'd0);
        for (int i = 0; i < 25; i++) chk($sformatf("init_byte%0d", i), log_tx[i], exp_init(i));

        // Single flush.
        lat = 2;
        b   = n_log;
        pulse_flush();
        chk("flush_busy", busy, 32'd1);
        t = 0;
        while (busy && t < 20000) begin @(negedge clk); t++; end
        chk("flush_end", busy, 32'd0);
        chk("flush_count", n_log - b, FLUSH_CMDS);
        for (int i = 0; i < 6; i++) chk($sformatf("win_byte%0d", i), log_tx[b+i], exp_win(i));
        chk("win_fn", log_fn[b+5], FN_W8);
        chk("start_fn", log_fn[b+6], FN_START);
        chk("ctrl_fn", log_fn[b+7], FN_RAW);
        chk("ctrl_tx", log_tx[b+7], 32'h40);
        bad = 0;
        for (int n = 0; n < 1024; n++)
            if (log_fn[b+8+n] !== FN_RAW || log_tx[b+8+n] !== 8'(n)) bad++;
        chk("data_bytes", bad, 32'd0);
        chk("stop_fn", log_fn[b+FLUSH_CMDS-1], FN_STOP);
        chk("fb_addr_last", fb_addr, 32'd1023);
        repeat (20) @(negedge clk);
        chk("no_reflush", n_log - b, FLUSH_CMDS);

        // Level held for two flushes, extra pulse mid-flush must not queue a third.
        b = n_log;
        k = n_stop;
        flush_req = 1'b1;
        t = 0;
        while (n_stop < k + 1 && t < 20000) begin @(negedge clk); t++; end
        chk("b2b_first_stop", n_stop, k + 1);
        repeat (100) @(negedge clk);
        flush_req = 1'b0;
        repeat (2000) @(negedge clk);
        pulse_flush();
        t = 0;
        while (busy && t < 20000) begin @(negedge clk); t++; end
        repeat (30) @(negedge clk);
        chk("b2b_busy", busy, 32'd0);
        chk("b2b_stops", n_stop, k + 2);
        chk("b2b_count", n_log - b, 2 * FLUSH_CMDS);
        chk("b2b_second_win", log_tx[b+FLUSH_CMDS], 32'h21);
        chk("b2b_gap", (log_cyc[b+FLUSH_CMDS] - log_cyc[b+FLUSH_CMDS-1] <= 10), 32'd1);

        // Reset in the middle of the data stream, then a full re-init.
        b = n_log;
        pulse_flush();
        t = 0;
        while (n_log < b + 308 && t < 20000) begin @(negedge clk); t++; end
        chk("mid_data_reached", (n_log >= b + 308), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        resetn = 1'b1;
        b = n_log;
        t = 0;
        while (!init_done && t < 4000) begin @(negedge clk); t++; end
        chk("reinit_done", init_done, 32'd1);
        chk("reinit_count", n_log - b, 32'd25);
        bad = 0;
        for (int i = 0; i < 25; i++) if (log_tx[b+i] !== exp_init(i) || log_fn[b+i] !== FN_W8) bad++;
        chk("reinit_bytes", bad, 32'd0);

        // Responder withholds done on data byte 300: watchdog trips.
        b       = n_log;
        hold_at = b + 8 + 300;
        pulse_flush();
        t = 0;
        while (n_log <= hold_at && t < 20000) begin @(negedge clk); t++; end
        chk("to_reached", (n_log > hold_at), 32'd1);
        repeat (TIMEOUT - 3) @(negedge clk);
        chk("to_early_err", err, 32'd0);
        chk("to_early_enable", bus.i2c_enable, 32'd1);
        repeat (5) @(negedge clk);
        chk("to_err", err, 32'd1);
        chk("to_enable", bus.i2c_enable, 32'd0);
        chk("to_function", bus.i2c_function, FN_IDLE);
        chk("to_busy", busy, 32'd0);
        k = n_log;
        pulse_flush();
        repeat (50) @(negedge clk);
        chk("err_sticky", err, 32'd1);
        chk("err_no_cmd", n_log, k);
        hold_at = -1;
        resetn  = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_reset", err, 32'd0);
        chk("err_reset_busy", busy, 32'd1);
        resetn = 1'b1;
        chk("hold_stable", stab_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
